// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals between the control unit, the ALU
// and the operation sequencer. The slave modport is the sequencer's view.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] y_out;
  logic [31:0] bus_out;
  logic [4:0]  alu_control;
  logic        alu_in;
  logic [63:0] z_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, z_in, rsp_ready,
    output req_ready, y_out, bus_out, alu_control, alu_in,
           rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, z_in, rsp_ready,
    input  req_ready, y_out, bus_out, alu_control, alu_in,
           rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: issues one op, waits a per-class settle time, returns Z.
// Optional macro ALU_SEQ_DIV0_TRAP_EN rejects divide-by-zero without touching the ALU.
module alu_op_sequencer #(
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 8,
  parameter int SIMPLE_CYCLES = 1
) (
  input logic                clock,
  input logic                clear,
  alu_op_sequencer_if.slave  seq
);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WAIT, CAPTURE, RESP} stateT;

  stateT       state;
  stateT       nextState;
  logic [7:0]  waitCount;
  logic [7:0]  settleCycles;
  logic [31:0] yReg;
  logic [31:0] busReg;
  logic [4:0]  aluCtlReg;
  logic [31:0] rspHiReg;
  logic [31:0] rspLoReg;
  logic        rspErrReg;
  logic        isLegal;
  logic        divTrap;
  logic        rejectReq;

  always_comb begin
    isLegal = 1'b0;
    case (seq.req_op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b01111, 5'b10000, 5'b10001, 5'b10010: isLegal = 1'b1;
      default:                                isLegal = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign divTrap = (seq.req_op == OP_DIV) && (seq.req_b == 32'd0);
`else
  assign divTrap = 1'b0;
`endif

  assign rejectReq = !isLegal || divTrap;

  // The latched opcode selects the settle class, so the request bus is free after accept.
  always_comb begin
    if (aluCtlReg == OP_MUL)
      settleCycles = 8'(MUL_CYCLES);
    else if (aluCtlReg == OP_DIV)
      settleCycles = 8'(DIV_CYCLES);
    else
      settleCycles = 8'(SIMPLE_CYCLES);
  end

  always_ff @(posedge clock) begin
    if (clear)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (seq.req_valid) nextState = rejectReq ? RESP : LOAD;
      LOAD:    nextState = EXEC;
      EXEC:    nextState = WAIT;
      WAIT:    if (waitCount <= 8'd1) nextState = CAPTURE;
      CAPTURE: nextState = RESP;
      RESP:    if (seq.rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operands are captured on the accept edge so they are already stable during LOAD.
  always_ff @(posedge clock) begin
    if (clear) begin
      yReg      <= '0;
      busReg    <= '0;
      aluCtlReg <= '0;
      rspHiReg  <= '0;
      rspLoReg  <= '0;
      rspErrReg <= 1'b0;
      waitCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seq.req_valid) begin
            if (rejectReq) begin
              rspHiReg  <= '0;
              rspLoReg  <= '0;
              rspErrReg <= 1'b1;
            end else begin
              yReg      <= seq.req_a;
              busReg    <= seq.req_b;
              aluCtlReg <= seq.req_op;
            end
          end
        end
        LOAD:    waitCount <= settleCycles;
        WAIT:    waitCount <= waitCount - 8'd1;
        CAPTURE: begin
          rspHiReg  <= seq.z_in[63:32];
          rspLoReg  <= seq.z_in[31:0];
          rspErrReg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    seq.req_ready   = (state == IDLE);
    seq.alu_in      = (state == EXEC);
    seq.rsp_valid   = (state == RESP);
    seq.y_out       = yReg;
    seq.bus_out     = busReg;
    seq.alu_control = aluCtlReg;
    seq.rsp_hi      = rspHiReg;
    seq.rsp_lo      = rspLoReg;
    seq.rsp_err     = rspErrReg;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on z_in.
// Divide-by-zero expectations follow ALU_SEQ_DIV0_TRAP_EN.
module tb_alu_op_sequencer;

  logic clock;
  logic clear;
  int   testsRun;
  int   testsFailed;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .clock (clock),
    .clear (clear),
    .seq   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: Z follows the operands and control the sequencer drives.
  logic [63:0] mulProduct;
  always_comb begin
    mulProduct = {{32{bus.y_out[31]}}, bus.y_out} * {{32{bus.bus_out[31]}}, bus.bus_out};
    case (bus.alu_control)
      5'b00011: bus.z_in = {32'd0, bus.y_out + bus.bus_out};
      5'b00100: bus.z_in = {32'd0, bus.y_out - bus.bus_out};
      5'b00101: bus.z_in = {32'd0, bus.y_out & bus.bus_out};
      5'b00110: bus.z_in = {32'd0, bus.y_out | bus.bus_out};
      5'b01111: bus.z_in = mulProduct;
      5'b10000: bus.z_in = (bus.bus_out == 32'd0) ? 64'hDEADBEEF_0BADF00D
                           : {bus.y_out % bus.bus_out, bus.y_out / bus.bus_out};
      default:  bus.z_in = 64'd0;
    endcase
  end

  // Issues one request and counts cycles after the accept edge until rsp_valid.
  task automatic runOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit holdValid, output int lat, output int pulseCycle,
                       output int pulses, output int readyHigh);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clock);
    #1;
    if (holdValid) begin
      bus.req_op = 5'b00011;
      bus.req_a  = 32'd1;
      bus.req_b  = 32'd1;
    end else begin
      bus.req_valid = 1'b0;
    end
    lat = -1; pulseCycle = -1; pulses = 0; readyHigh = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clock);
      if (bus.alu_in === 1'b1) begin
        pulses++;
        pulseCycle = k;
      end
      if (bus.rsp_valid === 1'b1) lat = k;
      else if (bus.req_ready !== 1'b0) readyHigh++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic finishRsp(output logic validAfter, output logic readyAfter);
    @(negedge clock);
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clock);
    validAfter = bus.rsp_valid;
    readyAfter = bus.req_ready;
  endtask

  task automatic test_reset;
    clear         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 5'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    testsRun++;
    if ({bus.req_ready, bus.rsp_valid, bus.alu_in, bus.rsp_err} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 1000",
               {bus.req_ready, bus.rsp_valid, bus.alu_in, bus.rsp_err});
    end
    testsRun++;
    if ({bus.y_out, bus.bus_out, bus.alu_control, bus.rsp_hi, bus.rsp_lo} !== 133'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got y=%h bus=%h ctl=%b hi=%h lo=%h expected all zero",
               bus.y_out, bus.bus_out, bus.alu_control, bus.rsp_hi, bus.rsp_lo);
    end
    clear = 1'b0;
  endtask

  task automatic test_add;
    int lat, pc, pn, rh;
    logic v, r;
    runOp(5'b00011, 32'd5, 32'd7, 1'b0, lat, pc, pn, rh);
    testsRun++;
    if (lat !== 5) begin testsFailed++; $display("[TB] FAIL add_latency: got %0d expected 5", lat); end
    testsRun++;
    if (pc !== 2 || pn !== 1) begin
      testsFailed++;
      $display("[TB] FAIL add_alu_in: got pulse at %0d count %0d expected at 2 count 1", pc, pn);
    end
    testsRun++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {32'd0, 32'd12, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL add_result: got hi=%h lo=%h err=%b expected 0/c/0", bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
    end
    testsRun++;
    if ({bus.y_out, bus.bus_out, bus.alu_control} !== {32'd5, 32'd7, 5'b00011}) begin
      testsFailed++;
      $display("[TB] FAIL add_operands: got y=%h bus=%h ctl=%b expected 5/7/00011", bus.y_out, bus.bus_out, bus.alu_control);
    end
    finishRsp(v, r);
    testsRun++;
    if ({v, r} !== 2'b01) begin testsFailed++; $display("[TB] FAIL add_handshake: got valid/ready %b expected 01", {v, r}); end
  endtask

  task automatic test_mul;
    int lat, pc, pn, rh;
    logic v, r;
    runOp(5'b01111, 32'hFFFFFFFF, 32'd2, 1'b0, lat, pc, pn, rh);
    testsRun++;
    if (lat !== 8 || pn !== 1) begin
      testsFailed++;
      $display("[TB] FAIL mul_latency: got %0d pulses %0d expected 8 pulses 1", lat, pn);
    end
    testsRun++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL mul_result: got hi=%h lo=%h err=%b expected ffffffff/fffffffe/0", bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
    end
    finishRsp(v, r);
    testsRun++;
    if ({v, r} !== 2'b01) begin testsFailed++; $display("[TB] FAIL mul_handshake: got valid/ready %b expected 01", {v, r}); end
  endtask

  // A second request is held valid for the whole divide and must be ignored.
  task automatic test_div;
    int lat, pc, pn, rh;
    logic v, r;
    runOp(5'b10000, 32'd17, 32'd5, 1'b1, lat, pc, pn, rh);
    testsRun++;
    if (lat !== 12 || pn !== 1) begin
      testsFailed++;
      $display("[TB] FAIL div_latency: got %0d pulses %0d expected 12 pulses 1", lat, pn);
    end
    testsRun++;
    if (rh !== 0) begin testsFailed++; $display("[TB] FAIL div_busy_ready: got %0d ready cycles expected 0", rh); end
    testsRun++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {32'd2, 32'd3, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL div_result: got hi=%h lo=%h err=%b expected 2/3/0", bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
    end
    finishRsp(v, r);
    testsRun++;
    if ({v, r} !== 2'b01) begin testsFailed++; $display("[TB] FAIL div_handshake: got valid/ready %b expected 01", {v, r}); end
  endtask

  task automatic test_illegal;
    int lat, pc, pn, rh, bad;
    logic v, r;
    runOp(5'b11111, 32'd9, 32'd9, 1'b0, lat, pc, pn, rh);
    testsRun++;
    if (lat !== 1 || pn !== 0) begin
      testsFailed++;
      $display("[TB] FAIL illegal_latency: got %0d pulses %0d expected 1 pulses 0", lat, pn);
    end
    testsRun++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {32'd0, 32'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL illegal_result: got hi=%h lo=%h err=%b expected 0/0/1", bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
    end
    testsRun++;
    if ({bus.y_out, bus.bus_out, bus.alu_control} !== {32'd17, 32'd5, 5'b10000}) begin
      testsFailed++;
      $display("[TB] FAIL illegal_operands_held: got y=%h bus=%h ctl=%b expected 11/5/10000", bus.y_out, bus.bus_out, bus.alu_control);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = 5'b00011;
    bus.req_a     = 32'd2;
    bus.req_b     = 32'd2;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.alu_in} !== 4'b1010 ||
          bus.rsp_lo !== 32'd0 || bus.rsp_hi !== 32'd0) bad++;
    end
    bus.req_valid = 1'b0;
    testsRun++;
    if (bad !== 0) begin testsFailed++; $display("[TB] FAIL illegal_stall: got %0d unstable cycles expected 0", bad); end
    finishRsp(v, r);
    testsRun++;
    if ({v, r} !== 2'b01) begin testsFailed++; $display("[TB] FAIL illegal_handshake: got valid/ready %b expected 01", {v, r}); end
  endtask

  // Next request waits on the handshake edge and is accepted on the edge after it.
  task automatic test_back_to_back;
    int lat, pc, pn, rh;
    logic v, r;
    runOp(5'b00110, 32'h0000F000, 32'h0000000F, 1'b0, lat, pc, pn, rh);
    testsRun++;
    if (lat !== 5 || bus.rsp_lo !== 32'h0000F00F) begin
      testsFailed++;
      $display("[TB] FAIL or_result: got lat %0d lo=%h expected 5/0000f00f", lat, bus.rsp_lo);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 5'b00100;
    bus.req_a     = 32'd10;
    bus.req_b     = 32'd3;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clock);
    testsRun++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ready_after_rsp: got valid/ready %b expected 01", {bus.rsp_valid, bus.req_ready});
    end
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clock);
      if (bus.rsp_valid === 1'b1) lat = k;
    end
    testsRun++;
    if (lat !== 5 || bus.rsp_lo !== 32'd7 || bus.rsp_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_sub: got lat %0d lo=%h err=%b expected 5/7/0", lat, bus.rsp_lo, bus.rsp_err);
    end
    finishRsp(v, r);
    testsRun++;
    if ({v, r} !== 2'b01) begin testsFailed++; $display("[TB] FAIL b2b_handshake: got valid/ready %b expected 01", {v, r}); end
  endtask

  task automatic test_clear_during_wait;
    int seen;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = 5'b10000;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd7;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    testsRun++;
    if ({bus.req_ready, bus.alu_in, bus.rsp_valid} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL clear_pre_wait: got ready/alu_in/valid %b expected 000", {bus.req_ready, bus.alu_in, bus.rsp_valid});
    end
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    testsRun++;
    if ({bus.req_ready, bus.rsp_valid, bus.alu_in, bus.rsp_err} !== 4'b1000 ||
        {bus.y_out, bus.bus_out, bus.alu_control, bus.rsp_hi, bus.rsp_lo} !== 133'd0) begin
      testsFailed++;
      $display("[TB] FAIL clear_state: got flags %b y=%h bus=%h ctl=%b hi=%h lo=%h expected 1000 and zeros",
               {bus.req_ready, bus.rsp_valid, bus.alu_in, bus.rsp_err},
               bus.y_out, bus.bus_out, bus.alu_control, bus.rsp_hi, bus.rsp_lo);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) seen++;
    end
    testsRun++;
    if (seen !== 0) begin testsFailed++; $display("[TB] FAIL clear_discard: got %0d bad cycles expected 0", seen); end
  endtask

  task automatic test_div_zero;
    int lat, pc, pn, rh;
    logic v, r;
    runOp(5'b10000, 32'd40, 32'd0, 1'b0, lat, pc, pn, rh);
`ifdef ALU_SEQ_DIV0_TRAP_EN
    testsRun++;
    if (lat !== 1 || pn !== 0) begin
      testsFailed++;
      $display("[TB] FAIL div0_latency: got %0d pulses %0d expected 1 pulses 0", lat, pn);
    end
    testsRun++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {32'd0, 32'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL div0_result: got hi=%h lo=%h err=%b expected 0/0/1", bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
    end
`else
    testsRun++;
    if (lat !== 12 || pn !== 1) begin
      testsFailed++;
      $display("[TB] FAIL div0_latency: got %0d pulses %0d expected 12 pulses 1", lat, pn);
    end
    testsRun++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {32'hDEADBEEF, 32'h0BADF00D, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL div0_result: got hi=%h lo=%h err=%b expected deadbeef/0badf00d/0", bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
    end
`endif
    finishRsp(v, r);
    testsRun++;
    if ({v, r} !== 2'b01) begin testsFailed++; $display("[TB] FAIL div0_handshake: got valid/ready %b expected 01", {v, r}); end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_clear_during_wait();
    test_div_zero();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
